// File: rtl/me_pkg.sv
// Shared motion-estimation types: scan move encoding, result FSM states, window-range helper.
package me_pkg;

    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;

    // Encoding shared with the motion-estimation controller's scan
    typedef enum logic [1:0] {
        MV_DOWN = 2'd0,
        MV_UP   = 2'd1,
        MV_LEFT = 2'd2,
        MV_HOLD = 2'd3
    } move_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic int range_of(input int search_dim, input int macro_dim);
        return search_dim - macro_dim + 1;
    endfunction

    localparam int RANGE = range_of(SEARCH_DIM_DEF, MACRO_DIM_DEF);

endpackage

// File: rtl/me_pos_tracker.sv
// Tracks the scan position from per-sample move codes, saturating at the window edge.
// Latency: candidate position is combinational in the sample cycle; registers update at the next edge.
// Backpressure: none; one move per cycle is always accepted.
module me_pos_tracker
    import me_pkg::*;
#(
    parameter int RANGE_P = 33,
    parameter int POS_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             first_i,
    input  logic [1:0]       sel_i,
    output logic [POS_W-1:0] cand_row_o,
    output logic [POS_W-1:0] cand_col_o,
    output logic             range_err_o
);

    localparam logic [POS_W-1:0] MAX_POS = POS_W'(RANGE_P - 1);

    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    logic             err_q, err_d;
    logic             oob;
    move_e            mv;

    assign mv = move_e'(sel_i);

    always_comb begin
        cand_row_o = row_q;
        cand_col_o = col_q;
        oob        = 1'b0;
        if (first_i) begin
            cand_row_o = '0;
            cand_col_o = '0;
        end else begin
            case (mv)
                MV_DOWN: if (row_q == '0)     oob = 1'b1; else cand_row_o = row_q - 1'b1;
                MV_UP:   if (row_q == MAX_POS) oob = 1'b1; else cand_row_o = row_q + 1'b1;
                MV_LEFT: if (col_q == MAX_POS) oob = 1'b1; else cand_col_o = col_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        err_d = err_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
            err_d = 1'b0;
        end else if (step_i) begin
            row_d = cand_row_o;
            col_d = cand_col_o;
            err_d = err_q | oob;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            err_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            err_q <= err_d;
        end
    end

    assign range_err_o = err_q;

endmodule

// File: rtl/me_best_match.sv
// Keeps the minimum-SAD candidate of a snake scan and offers its motion vector to mode decision.
// Latency: done at cycle t gives res_valid at t+1, covering every sample up to and including t.
// Backpressure: none on the sample input; the result is held until res_ready, start aborts it.
module me_best_match
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    input  logic [1:0]       sel,
    input  logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       mv_x,
    output logic [5:0]       mv_y,
    output logic [SAD_W-1:0] best_sad,
    output logic [10:0]      cand_cnt,
    output logic             range_err
);

    localparam int RNG   = range_of(SEARCH_DIM, MACRO_DIM);
    localparam int POS_W = $clog2(RNG);
    localparam int HALF  = (RNG - 1) / 2;
    localparam logic [POS_W-1:0] CENTER = POS_W'(HALF);

    state_e           state_q, state_d;
    logic [SAD_W-1:0] best_sad_q;
    logic [POS_W-1:0] best_row_q, best_col_q;
    logic [POS_W-1:0] cand_row, cand_col;
    logic [10:0]      cand_cnt_q;
    logic             first_q;
    logic             scoring;

    assign scoring = (state_q == ST_SCAN) && sad_valid && !start;

    me_pos_tracker #(
        .RANGE_P (RNG),
        .POS_W   (POS_W)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start),
        .step_i      (scoring),
        .first_i     (first_q),
        .sel_i       (sel),
        .cand_row_o  (cand_row),
        .cand_col_o  (cand_col),
        .range_err_o (range_err)
    );

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_SCAN: if (done) state_d = ST_HOLD;
                ST_HOLD: if (res_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Strict less-than keeps the earliest of equal minima
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad_q <= '1;
            best_row_q <= CENTER;
            best_col_q <= CENTER;
            cand_cnt_q <= '0;
            first_q    <= 1'b0;
        end else if (start) begin
            best_sad_q <= '1;
            best_row_q <= '0;
            best_col_q <= '0;
            cand_cnt_q <= '0;
            first_q    <= 1'b1;
        end else if (scoring) begin
            first_q <= 1'b0;
            if (cand_cnt_q != '1) cand_cnt_q <= cand_cnt_q + 11'd1;
            if (sad < best_sad_q) begin
                best_sad_q <= sad;
                best_row_q <= cand_row;
                best_col_q <= cand_col;
            end
        end
    end

    assign res_valid = (state_q == ST_HOLD);
    assign mv_x      = 6'(best_col_q) - 6'(HALF);
    assign mv_y      = 6'(best_row_q) - 6'(HALF);
    assign best_sad  = best_sad_q;
    assign cand_cnt  = cand_cnt_q;

endmodule

// File: tb/tb_me_best_match.sv
// Bench for me_best_match: directed scenarios plus random scans against an integer position/minimum model.
module tb_me_best_match;

    localparam int RANGE = 33;
    localparam int HALF  = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, sad_valid, done, res_ready, res_valid, range_err;
    logic [15:0] sad, best_sad;
    logic [1:0]  sel;
    logic [5:0]  mv_x, mv_y;
    logic [10:0] cand_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_row, m_col, m_brow, m_bcol, m_best, m_cnt;
    bit m_first, m_err;

    always #5 clk = ~clk;

    me_best_match #(.MACRO_DIM(16), .SEARCH_DIM(48), .SAD_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .sel       (sel),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .best_sad  (best_sad),
        .cand_cnt  (cand_cnt),
        .range_err (range_err)
    );

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_brow = HALF; m_bcol = HALF;
        m_best = 16'hFFFF; m_cnt = 0; m_first = 0; m_err = 0;
    endfunction

    function automatic void model_start();
        m_row = 0; m_col = 0; m_brow = 0; m_bcol = 0;
        m_best = 16'hFFFF; m_cnt = 0; m_first = 1; m_err = 0;
    endfunction

    function automatic void model_sample(input int s, input int m);
        if (m_first) begin
            m_row = 0; m_col = 0;
        end else if (m == 0) begin
            if (m_row == 0) m_err = 1; else m_row--;
        end else if (m == 1) begin
            if (m_row == RANGE - 1) m_err = 1; else m_row++;
        end else if (m == 2) begin
            if (m_col == RANGE - 1) m_err = 1; else m_col++;
        end
        m_first = 0;
        if (m_cnt < 2047) m_cnt++;
        if (s < m_best) begin
            m_best = s; m_brow = m_row; m_bcol = m_col;
        end
    endfunction

    function automatic logic [40:0] exp_vec(input logic rv);
        logic [5:0] ex, ey;
        ex = 6'(m_bcol - HALF);
        ey = 6'(m_brow - HALF);
        return {rv, ex, ey, 16'(m_best), 11'(m_cnt), m_err};
    endfunction

    function automatic logic [40:0] act_vec();
        return {res_valid, mv_x, mv_y, best_sad, cand_cnt, range_err};
    endfunction

    // Drives one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic st, input logic v, input logic [15:0] s,
                       input logic [1:0] m, input logic d, input logic rdy);
        start = st; sad_valid = v; sad = s; sel = m; done = d; res_ready = rdy;
        @(negedge clk);
    endtask

    task automatic begin_scan();
        cyc(1, 0, 0, 0, 0, 0);
        model_start();
    endtask

    task automatic sample(input int s, input int m, input logic d);
        cyc(0, 1, 16'(s), 2'(m), d, 0);
        model_sample(s, m);
    endtask

    task automatic release_result();
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (act_vec() !== exp_vec(0)) begin
            n_bad++;
            $display("FAIL release got %h want %h", act_vec(), exp_vec(0));
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        cyc(0, 0, 0, 0, 0, 0);
        model_reset();
        n_cmp++;
        if (act_vec() !== exp_vec(0)) begin
            n_bad++;
            $display("FAIL reset_state got %h want %h", act_vec(), exp_vec(0));
        end
        rst_n = 1;
        cyc(0, 1, 16'd5, 2'd1, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        n_cmp++;
        if (act_vec() !== exp_vec(0)) begin
            n_bad++;
            $display("FAIL idle_ignores got %h want %h", act_vec(), exp_vec(0));
        end
    endtask

    task automatic test_up_scan();
        begin_scan();
        sample(1000, 3, 0);
        for (int k = 1; k <= 33; k++) sample((k == 20) ? 50 : 1000, 1, 0);
        sample(1000, 2, 0);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL up_scan_early_valid got %b want 0", res_valid);
        end
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (act_vec() !== {1'b1, 6'h30, 6'd4, 16'd50, 11'd35, 1'b1}) begin
            n_bad++;
            $display("FAIL up_scan got %h want %h", act_vec(),
                     {1'b1, 6'h30, 6'd4, 16'd50, 11'd35, 1'b1});
        end
        release_result();
    endtask

    task automatic test_tie();
        begin_scan();
        for (int k = 0; k < 14; k++) sample((k == 3 || k == 10) ? 7 : 500, (k == 0) ? 3 : 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (act_vec() !== {1'b1, 6'h30, 6'h33, 16'd7, 11'd14, 1'b0}) begin
            n_bad++;
            $display("FAIL tie_first got %h want %h", act_vec(),
                     {1'b1, 6'h30, 6'h33, 16'd7, 11'd14, 1'b0});
        end
        release_result();
    endtask

    task automatic test_done_coincident();
        begin_scan();
        for (int k = 0; k < 6; k++) sample(20 + k, (k == 0) ? 3 : 2, 0);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL coincident_pre got %b want 0", res_valid);
        end
        sample(0, 1, 1);
        n_cmp++;
        if (act_vec() !== exp_vec(1) || best_sad !== 16'd0) begin
            n_bad++;
            $display("FAIL coincident got %h want %h", act_vec(), exp_vec(1));
        end
        release_result();
    endtask

    task automatic test_hold_stall();
        int bad_cycles = 0;
        begin_scan();
        for (int k = 0; k < 9; k++) sample($urandom_range(10, 300), (k == 0) ? 3 : $urandom_range(1, 2), 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1'($urandom), 16'd0, 2'($urandom), 1'($urandom), 0);
            if (act_vec() !== exp_vec(1)) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL hold_stable got %0d changed cycles want 0 (now %h, want %h)",
                     bad_cycles, act_vec(), exp_vec(1));
        end
        release_result();
    endtask

    task automatic test_range_err();
        begin_scan();
        sample(100, 3, 0);
        sample(90, 0, 0);
        n_cmp++;
        if (range_err !== 1'b1) begin
            n_bad++;
            $display("FAIL range_err_set got %b want 1", range_err);
        end
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (act_vec() !== exp_vec(1) || mv_y !== 6'h30) begin
            n_bad++;
            $display("FAIL range_sat got %h want %h", act_vec(), exp_vec(1));
        end
        begin_scan();
        n_cmp++;
        if (act_vec() !== exp_vec(0) || range_err !== 1'b0) begin
            n_bad++;
            $display("FAIL start_abort got %h want %h", act_vec(), exp_vec(0));
        end
    endtask

    task automatic test_reset_mid_scan();
        int spurious = 0;
        begin_scan();
        for (int k = 0; k < 5; k++) sample(3, (k == 0) ? 3 : 1, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (act_vec() !== exp_vec(0)) begin
            n_bad++;
            $display("FAIL async_reset got %h want %h", act_vec(), exp_vec(0));
        end
        @(negedge clk);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0, 0);
        begin_scan();
        for (int c = 0; c < RANGE; c++) begin
            for (int r = 0; r < RANGE; r++) begin
                int m;
                if (r == 0) m = (c == 0) ? 3 : 2;
                else        m = (c % 2 == 0) ? 1 : 0;
                sample($urandom_range(200, 60000), m, 0);
                if (res_valid !== 1'b0) spurious++;
            end
        end
        n_cmp++;
        if (spurious != 0) begin
            n_bad++;
            $display("FAIL snake_spurious got %0d valid cycles want 0", spurious);
        end
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (act_vec() !== exp_vec(1) || cand_cnt !== 11'd1089) begin
            n_bad++;
            $display("FAIL snake_full got %h want %h", act_vec(), exp_vec(1));
        end
        release_result();
    endtask

    task automatic test_saturate();
        begin_scan();
        for (int k = 0; k < 2100; k++) sample(1000, 3, 0);
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (act_vec() !== exp_vec(1) || cand_cnt !== 11'd2047) begin
            n_bad++;
            $display("FAIL cnt_saturate got %h want %h", act_vec(), exp_vec(1));
        end
        release_result();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic coinc;
            begin_scan();
            n = $urandom_range(1, 60);
            coinc = 1'($urandom);
            for (int k = 0; k < n; k++) begin
                int s;
                s = ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, 400);
                sample(s, $urandom_range(0, 3), coinc && (k == n - 1));
            end
            if (!coinc) cyc(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (act_vec() !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL random_%0d got %h want %h", it, act_vec(), exp_vec(1));
            end
            repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0, 0, 0);
            release_result();
        end
    endtask

    initial begin
        rst_n = 0; start = 0; sad_valid = 0; sad = 0; sel = 0; done = 0; res_ready = 0;
        @(negedge clk);
        test_reset();
        test_up_scan();
        test_tie();
        test_done_coincident();
        test_hold_stall();
        test_range_err();
        test_reset_mid_scan();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
